mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported RAM/MMIO block between the instruction-fetch port (read-only) and the load/store data port.
- Latches one request at a time, sequences the memory control lines, and holds address/re/we stable for the whole read window, because the RAM read mux and breakpoint compare decode the live address.
- Returns registered read data, and a breakpoint flag, with a one-cycle ack.
- Sits between the CPU core and RAM.

Parameters:
- READ_LATENCY, 1: cycles from address-sampling edge to valid mem_rdata; legal range 1..7.
- MAX_STREAK, 4: consecutive data grants allowed while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request (level)
- f_addr  in  32  fetch address
- f_gnt  out  1  fetch request accepted this cycle
- f_ack  out  1  fetch complete, one-cycle pulse
- f_rdata  out  16  fetch read data
- f_bp  out  1  breakpoint hit on the acked fetch
- d_req  in  1  data request (level)
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  16  write data
- d_gnt  out  1  data request accepted this cycle
- d_ack  out  1  data complete, one-cycle pulse
- d_rdata  out  16  data read data
- d_bp  out  1  breakpoint hit on the acked data access
- mem_addr  out  32  to RAM addrIn
- mem_write  out  16  to RAM write
- mem_we  out  1  to RAM we
- mem_re  out  1  to RAM re
- mem_rdata  in  16  from RAM read
- mem_is_bp  in  1  from RAM isBP
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low), applied immediately:
  - state IDLE; streak counter 0.
  - mem_addr, mem_write, mem_we, mem_re, f_rdata, d_rdata: all 0.
  - f_ack, d_ack, f_bp, d_bp, busy: all 0.
  - f_gnt and d_gnt forced 0 while rst is low.
- Reset mid-transaction: the transaction is dropped, no ack is issued, and mem_re/mem_we fall to 0 asynchronously.
- States: IDLE -> ISSUE -> (WAIT ×READ_LATENCY, read only) -> ACK -> IDLE.
- IDLE:
  - gnt is combinational and equals (state==IDLE) & selected req.
  - On a grant, the grantee's addr, wdata and we plus the port ID are latched at the clock edge; next state is ISSUE.
- Arbitration in IDLE:
  - Data port wins by default.
  - Fetch wins when f_req is high and streak==MAX_STREAK, or when d_req is low.
  - Streak increments on a data grant while f_req is high (saturates at MAX_STREAK).
  - Streak clears on a fetch grant, or on a data grant with f_req low.
- ISSUE (1 cycle):
  - mem_addr = latched address.
  - mem_we = latched we; mem_re = !latched we; mem_write = latched wdata.
  - Breakpoint flag is latched from mem_is_bp.
  - Write: next state is ACK. Read: next state is WAIT with counter = READ_LATENCY.
- WAIT:
  - mem_addr and mem_re are held unchanged.
  - Counter decrements each cycle.
  - In the final WAIT cycle (counter==1), mem_rdata is captured into the grantee's rdata register; next state is ACK.
- ACK (1 cycle):
  - Grantee's ack = 1 and its bp = latched flag.
  - mem_re = mem_we = 0 and mem_addr = 0.
  - Next state is IDLE.
- rdata registers hold their value until the next read capture on the same port; writes do not alter d_rdata.
- bp outputs are valid only while the matching ack is high; otherwise 0.
- Latency from grant cycle to ack: write 2 cycles; read READ_LATENCY+2 cycles.
- Throughput: one access per 3 cycles (write) or READ_LATENCY+3 cycles (read); no grant is issued in the ACK cycle.
- Requester protocol:
  - A requester may change addr/data and drop req after gnt.
  - A requester must not expect a new gnt before its ack.
  - A req held high after gnt is treated as a new request in the next IDLE.
- mem_we is never high for more than one cycle per transaction; mem_re and mem_we are never both high.

Test Plan:
- Reset, then d_req=1, d_we=1, d_addr=0xD0000010, d_wdata=0xBEEF -> d_gnt in cycle 0; mem_we=1 with mem_addr=0xD0000010 in cycle 1 only; d_ack pulse in cycle 2; then a data read of the same address -> d_rdata=0xBEEF with d_ack 3 cycles after gnt (READ_LATENCY=1).
- f_req and d_req held high together continuously, MAX_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; streak clears on each fetch grant.
- Read with READ_LATENCY=3 -> mem_re and mem_addr stay stable across ISSUE plus 3 WAIT cycles; capture happens in the last WAIT cycle; ack arrives 5 cycles after gnt.
- mem_is_bp=1 during the ISSUE of a fetch to 0x00000040 -> f_ack and f_bp high in the same cycle; d_bp stays 0; the next non-BP access returns bp=0.
- rst low during WAIT of a read -> mem_re=0 immediately; no ack issued; after release, state is IDLE, busy=0, rdata=0, and a new request is granted normally.
- d_req high in the ACK cycle of a fetch -> no grant in that cycle; d_gnt in the following IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported RAM/MMIO block between the instruction-fetch port
// (read-only) and the load/store data port. One request is latched at a time;
// address, re and we are held stable for the whole read window because the RAM
// read mux and the breakpoint comparator decode the live address.
//
// Ports
//   clk, rst                      rising-edge clock, async active-low reset
//   f_req/f_addr                  fetch request (level) and address
//   f_gnt/f_ack/f_rdata/f_bp      fetch accept, done pulse, read data, bp hit
//   d_req/d_we/d_addr/d_wdata     data request, 1=write, address, write data
//   d_gnt/d_ack/d_rdata/d_bp      data accept, done pulse, read data, bp hit
//   mem_addr/mem_write/mem_we/mem_re   RAM address, write data and strobes
//   mem_rdata/mem_is_bp           RAM read data and breakpoint hit
//   busy                          high whenever the FSM is not IDLE
//
// Sequence: IDLE -> ISSUE -> (WAIT x READ_LATENCY, reads only) -> ACK -> IDLE.
// Grant to ack is 2 cycles for a write and READ_LATENCY+2 for a read.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,  // 1..7
    parameter int unsigned MAX_STREAK   = 4   // 1..15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    output logic        f_bp,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        d_bp,

    output logic [31:0] mem_addr,
    output logic [15:0] mem_write,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        mem_is_bp,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [2:0] LAT_INIT   = 3'(READ_LATENCY);

    state_e      state_q;
    logic [3:0]  streak_q, streak_d;
    logic [2:0]  wait_cnt_q;
    logic        port_f_q;      // 1 = current transaction belongs to fetch
    logic        bp_lat_q;      // breakpoint sampled during ISSUE of a read
    logic [31:0] mem_addr_q;
    logic [15:0] mem_write_q;
    logic        mem_we_q, mem_re_q;
    logic [15:0] f_rdata_q, d_rdata_q;
    logic        f_ack_q, d_ack_q, f_bp_q, d_bp_q;

    // Data wins by default; fetch wins once the data port has used up its
    // streak, or whenever data is not asking.
    logic idle, f_win, d_win;
    assign idle  = (state_q == S_IDLE);
    assign f_win = f_req & ((streak_q == STREAK_MAX) | ~d_req);
    assign d_win = d_req & ~f_win;

    // Grants are combinational and forced low while reset is asserted.
    assign f_gnt = rst & idle & f_win;
    assign d_gnt = rst & idle & d_win;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        streak_d = streak_q;
        if (f_gnt) begin
            streak_d = '0;
        end else if (d_gnt) begin
            if (!f_req)                      streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the ack/bp
    // defaults at the top are overridden later in the same block where a
    // transaction completes, which makes them one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            wait_cnt_q  <= '0;
            port_f_q    <= 1'b0;
            bp_lat_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_bp_q      <= 1'b0;
            d_bp_q      <= 1'b0;
        end else begin
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            f_bp_q   <= 1'b0;
            d_bp_q   <= 1'b0;
            streak_q <= streak_d;

            unique case (state_q)
                S_IDLE: begin
                    // Strobes are loaded here so they are already valid
                    // throughout the ISSUE cycle.
                    if (f_gnt || d_gnt) begin
                        port_f_q    <= f_gnt;
                        mem_addr_q  <= f_gnt ? f_addr : d_addr;
                        mem_write_q <= f_gnt ? 16'h0 : d_wdata;
                        mem_we_q    <= d_gnt & d_we;
                        mem_re_q    <= f_gnt | ~d_we;
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (mem_we_q) begin
                        // Write completes straight away; bp goes out with ack.
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                        d_ack_q    <= ~port_f_q;
                        f_ack_q    <= port_f_q;
                        d_bp_q     <= ~port_f_q & mem_is_bp;
                        f_bp_q     <= port_f_q & mem_is_bp;
                        state_q    <= S_ACK;
                    end else begin
                        bp_lat_q   <= mem_is_bp;
                        wait_cnt_q <= LAT_INIT;
                        state_q    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Address and re stay untouched until the final WAIT
                    // cycle, where the read data is captured.
                    wait_cnt_q <= wait_cnt_q - 3'd1;
                    if (wait_cnt_q == 3'd1) begin
                        if (port_f_q) f_rdata_q <= mem_rdata;
                        else          d_rdata_q <= mem_rdata;
                        mem_re_q   <= 1'b0;
                        mem_addr_q <= '0;
                        f_ack_q    <= port_f_q;
                        d_ack_q    <= ~port_f_q;
                        f_bp_q     <= port_f_q & bp_lat_q;
                        d_bp_q     <= ~port_f_q & bp_lat_q;
                        state_q    <= S_ACK;
                    end
                end

                S_ACK: begin
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_bp      = f_bp_q;
    assign d_bp      = d_bp_q;
    assign busy      = ~idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Instance A (READ_LATENCY=1, MAX_STREAK=4) talks to a small behavioural RAM
// whose contents start at {8'hA5, index} and whose breakpoint fires on
// address 0x40. Instance B (READ_LATENCY=3) returns ~address as read data.
// Expected acks are queued at grant time and compared when the ack appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] BP_ADDR = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int viol    = 0;
    int we_run  = 0;

    always @(posedge clk) cyc++;

    // ---------------- instance A ----------------
    logic        a_f_req, a_f_gnt, a_f_ack, a_f_bp;
    logic [31:0] a_f_addr;
    logic [15:0] a_f_rdata;
    logic        a_d_req, a_d_we, a_d_gnt, a_d_ack, a_d_bp;
    logic [31:0] a_d_addr;
    logic [15:0] a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr;
    logic [15:0] a_mem_write, a_mem_rdata;
    logic        a_mem_we, a_mem_re, a_mem_is_bp, a_busy;

    mem_port_arbiter #(.READ_LATENCY(1), .MAX_STREAK(4)) dut_a (
        .clk(clk), .rst(rst),
        .f_req(a_f_req), .f_addr(a_f_addr), .f_gnt(a_f_gnt), .f_ack(a_f_ack),
        .f_rdata(a_f_rdata), .f_bp(a_f_bp),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_ack(a_d_ack), .d_rdata(a_d_rdata), .d_bp(a_d_bp),
        .mem_addr(a_mem_addr), .mem_write(a_mem_write), .mem_we(a_mem_we),
        .mem_re(a_mem_re), .mem_rdata(a_mem_rdata), .mem_is_bp(a_mem_is_bp),
        .busy(a_busy)
    );

    logic [15:0] ram_a [0:255];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram_a[i] <= {8'hA5, 8'(i)};
            ram_loaded <= 1'b1;
        end else if (a_mem_we) begin
            ram_a[a_mem_addr[7:0]] <= a_mem_write;
        end
    end
    assign a_mem_rdata = a_mem_re ? ram_a[a_mem_addr[7:0]] : 16'h0;
    assign a_mem_is_bp = (a_mem_re | a_mem_we) & (a_mem_addr == BP_ADDR);

    // ---------------- instance B ----------------
    logic        b_f_req, b_f_gnt, b_f_ack, b_f_bp;
    logic [31:0] b_f_addr;
    logic [15:0] b_f_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_ack, b_d_bp;
    logic [31:0] b_d_addr;
    logic [15:0] b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr;
    logic [15:0] b_mem_write, b_mem_rdata;
    logic        b_mem_we, b_mem_re, b_mem_is_bp, b_busy;

    mem_port_arbiter #(.READ_LATENCY(3), .MAX_STREAK(4)) dut_b (
        .clk(clk), .rst(rst),
        .f_req(b_f_req), .f_addr(b_f_addr), .f_gnt(b_f_gnt), .f_ack(b_f_ack),
        .f_rdata(b_f_rdata), .f_bp(b_f_bp),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_bp(b_d_bp),
        .mem_addr(b_mem_addr), .mem_write(b_mem_write), .mem_we(b_mem_we),
        .mem_re(b_mem_re), .mem_rdata(b_mem_rdata), .mem_is_bp(b_mem_is_bp),
        .busy(b_busy)
    );

    assign b_mem_rdata = b_mem_re ? ~b_mem_addr[15:0] : 16'h0;
    assign b_mem_is_bp = 1'b0;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          port_f;
        logic [15:0] rdata;
        bit          bp;
        int          lat;
        int          gcyc;
    } exp_t;

    exp_t sb[$];

    task automatic push(input bit port_f, input logic [15:0] rdata, input bit bp, input int lat);
        exp_t e;
        e.port_f = port_f;
        e.rdata  = rdata;
        e.bp     = bp;
        e.lat    = lat;
        e.gcyc   = cyc;
        sb.push_back(e);
    endtask

    // Ack monitor and strobe-rule watcher for instance A.
    always @(negedge clk) begin
        if (rst) begin
            if (a_mem_we) we_run++; else we_run = 0;
            if (we_run > 1 || (a_mem_we && a_mem_re)) viol++;
            if (a_f_ack || a_d_ack) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got f_ack=%0b d_ack=%0b expected none", a_f_ack, a_d_ack);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_port", {a_f_ack, a_d_ack}, e.port_f ? 2'b10 : 2'b01);
                    check("ack_rdata", e.port_f ? a_f_rdata : a_d_rdata, e.rdata);
                    check("ack_bp", e.port_f ? a_f_bp : a_d_bp, e.bp);
                    check("other_bp", e.port_f ? a_d_bp : a_f_bp, 1'b0);
                    check("ack_latency", cyc - e.gcyc, e.lat);
                end
            end
        end
    end

    // Waits (bounded) until every queued ack has been seen; ends just after a
    // rising edge, ready to drive the next request.
    task automatic wait_sb_empty();
        int t;
        for (t = 0; t < 30; t++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        if (t == 30) begin
            check("ack_timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
    endtask

    // Single transaction on instance A: request, bounded grant wait, queue
    // expectation, drop the request, wait for the ack.
    task automatic do_txn(input bit port_f, input bit we, input logic [31:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata,
                          input bit exp_bp);
        bit got = 1'b0;
        if (port_f) begin
            a_f_req = 1'b1; a_f_addr = addr;
        end else begin
            a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (port_f ? a_f_gnt : a_d_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("txn_grant", got, 1'b1);
        if (got) push(port_f, exp_rdata, exp_bp, we ? 2 : 3);
        @(posedge clk); #1;
        a_f_req = 1'b0; a_d_req = 1'b0;
        a_f_addr = '0; a_d_addr = '0; a_d_wdata = '0; a_d_we = 1'b0;
        wait_sb_empty();
    endtask

    typedef struct {
        bit          port_f;
        bit          we;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          exp_bp;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        // Written before the first reset release; expected values assume the
        // 0xBEEF write of the opening sequence has landed at index 0x10.
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 16'h0000, 16'hA540, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0044, 16'h0000, 16'hA544, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0020, 16'h0000, 16'hA520, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0020, 16'h1234, 16'hA520, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0020, 16'h0000, 16'h1234, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0040, 16'h5555, 16'h1234, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0040, 16'h0000, 16'h5555, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_00FF, 16'h0000, 16'hA5FF, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0010, 16'h0000, 16'hBEEF, 1'b0};

        rst = 1'b0;
        a_f_req = 1'b1; a_f_addr = 32'h44; a_d_req = 1'b1; a_d_we = 1'b1;
        a_d_addr = 32'h20; a_d_wdata = 16'hFFFF;
        b_f_req = 1'b0; b_f_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_addr = '0; b_d_wdata = '0;

        // ---- reset state, requests high but grants must stay low ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {a_f_gnt, a_d_gnt}, 2'b00);
        check("rst_mem_addr", a_mem_addr, 32'h0);
        check("rst_mem_strobes", {a_mem_we, a_mem_re, a_mem_write}, 18'h0);
        check("rst_acks_bp_busy", {a_f_ack, a_d_ack, a_f_bp, a_d_bp, a_busy}, 5'b0);
        check("rst_rdata", {a_f_rdata, a_d_rdata}, 32'h0);
        a_f_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0; a_f_addr = '0;
        a_d_addr = '0; a_d_wdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- data write then read back (READ_LATENCY=1) ----
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'hD000_0010; a_d_wdata = 16'hBEEF;
        @(negedge clk);
        check("wr_gnt_c0", {a_d_gnt, a_f_gnt}, 2'b10);
        push(1'b0, 16'h0000, 1'b0, 2);
        @(posedge clk); #1;
        a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
        @(negedge clk);
        check("wr_strobes_c1", {a_mem_we, a_mem_re, a_busy}, 3'b101);
        check("wr_addr_c1", a_mem_addr, 32'hD000_0010);
        check("wr_data_c1", a_mem_write, 16'hBEEF);
        @(negedge clk);
        check("wr_we_low_c2", a_mem_we, 1'b0);
        wait_sb_empty();
        do_txn(1'b0, 1'b0, 32'hD000_0010, 16'h0, 16'hBEEF, 1'b0);

        // ---- table of single transactions ----
        for (int i = 0; i < 9; i++)
            do_txn(vecs[i].port_f, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_bp);

        // ---- both requesters held high: D,D,D,D,F repeating ----
        a_f_req = 1'b1; a_f_addr = 32'h44;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            bit got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (a_f_gnt || a_d_gnt) begin
                    got = 1'b1;
                    break;
                end
            end
            check($sformatf("order_grant_%0d", i), got, 1'b1);
            if (!got) break;
            check($sformatf("order_who_%0d", i), {a_f_gnt, a_d_gnt},
                  (i % 5 == 4) ? 2'b10 : 2'b01);
            if (a_f_gnt) push(1'b1, 16'hA544, 1'b0, 3);
            else         push(1'b0, 16'h1234, 1'b0, 3);
        end
        @(posedge clk); #1;
        a_f_req = 1'b0; a_d_req = 1'b0; a_f_addr = '0; a_d_addr = '0;
        wait_sb_empty();

        // ---- d_req raised during a fetch: no grant in its ACK cycle ----
        begin
            bit seen = 1'b0;
            a_f_req = 1'b1; a_f_addr = 32'h44;
            @(negedge clk);
            check("ackgap_f_gnt", a_f_gnt, 1'b1);
            push(1'b1, 16'hA544, 1'b0, 3);
            @(posedge clk); #1;
            a_f_req = 1'b0; a_f_addr = '0;
            a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                check("ackgap_no_gnt", a_d_gnt, 1'b0);
                if (a_f_ack) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("ackgap_ack_seen", seen, 1'b1);
            @(negedge clk);
            check("ackgap_gnt_next", a_d_gnt, 1'b1);
            push(1'b0, 16'h1234, 1'b0, 3);
            @(posedge clk); #1;
            a_d_req = 1'b0; a_d_addr = '0;
            wait_sb_empty();
        end

        // ---- READ_LATENCY=3 on instance B ----
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h0000_1230;
        @(negedge clk);
        check("lat3_gnt", b_d_gnt, 1'b1);
        @(posedge clk); #1;
        b_d_req = 1'b0; b_d_addr = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("lat3_re_%0d", k), {b_mem_re, b_mem_we, b_d_ack}, 3'b100);
            check($sformatf("lat3_addr_%0d", k), b_mem_addr, 32'h0000_1230);
            check($sformatf("lat3_rdata_hold_%0d", k), b_d_rdata, 16'h0000);
        end
        @(negedge clk);
        check("lat3_ack_c5", b_d_ack, 1'b1);
        check("lat3_rdata", b_d_rdata, 16'hEDCF);
        check("lat3_idle_bus", {b_mem_re, b_mem_addr}, 33'h0);
        @(negedge clk);
        check("lat3_done", {b_d_ack, b_busy}, 2'b00);
        @(posedge clk); #1;
        b_d_addr = '0;

        // ---- reset during WAIT of a read ----
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
        @(negedge clk);
        check("rstmid_gnt", a_d_gnt, 1'b1);
        @(posedge clk); #1;
        a_d_req = 1'b0; a_d_addr = '0;
        @(posedge clk); #2;
        check("rstmid_in_wait", {a_mem_re, a_busy}, 2'b11);
        rst = 1'b0;
        #1;
        check("rstmid_strobes", {a_mem_re, a_mem_we, a_busy}, 3'b000);
        check("rstmid_addr", a_mem_addr, 32'h0);
        check("rstmid_rdata", {a_f_rdata, a_d_rdata}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstmid_no_ack", {a_f_ack, a_d_ack}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_idle", {a_busy, a_f_ack, a_d_ack}, 3'b000);
        @(posedge clk); #1;
        do_txn(1'b0, 1'b0, 32'h20, 16'h0, 16'h1234, 1'b0);

        check("mem_strobe_rules", viol, 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
